// File: rtl/vga_pkg.sv
// Shared constants for the memory-game VGA path.
// Timing, grid geometry, colours and rgb9 channel slices.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_TOTAL   = 800;
   localparam int V_VISIBLE = 480;
   localparam int V_TOTAL   = 525;

   localparam int GRID_X0 = 121;
   localparam int GRID_Y0 = 60;
   localparam int CELL    = 100;

   typedef logic [8:0] rgb9_t;

   localparam rgb9_t BG_RGB     = 9'b000_010_000;
   localparam rgb9_t CURSOR_RGB = 9'b111_111_000;

   localparam int R_HI = 8;
   localparam int R_LO = 6;
   localparam int G_HI = 5;
   localparam int G_LO = 3;
   localparam int B_HI = 2;
   localparam int B_LO = 0;

   // Halve every channel independently (logical shift right by one).
   function automatic rgb9_t rgb9_dim(input rgb9_t c);
      return {1'b0, c[R_HI:R_LO+1],
              1'b0, c[G_HI:G_LO+1],
              1'b0, c[B_HI:B_LO+1]};
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Parameterised shift register with async active-low reset.
// Reset loads every stage with RST_VAL (the inactive level).
module sig_delay #(
   parameter int             W       = 1,
   parameter int             DEPTH   = 2,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   // Shift one stage per clock; reset clears to the inactive value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_compositor.sv
// Final VGA stage: merges 16 card layers, cursor and background.
// Syncs are delayed to match the card pipeline, then registered.
module vga_pixel_compositor
   import vga_pkg::*;
#(
   parameter int CARD_LAT  = 2,
   parameter int NCARDS    = 16,
   parameter int BORDER    = 3,
   parameter int BLINK_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        HCount,
   input  logic [9:0]        VCount,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              video_on_in,
   input  logic [NCARDS-1:0] card_on,
   input  logic [9*NCARDS-1:0] card_rgb,
   input  logic [NCARDS-1:0] matched,
   input  logic [3:0]        cursor_pos,
   input  logic              cursor_en,
   output logic              hsync,
   output logic              vsync,
   output logic [8:0]        rgb
);

   logic [9:0] hcount_d;
   logic [9:0] vcount_d;
   logic       hsync_d;
   logic       vsync_d;
   logic       video_on_d;

   sig_delay #(.W(20), .DEPTH(CARD_LAT), .RST_VAL(20'd0)) u_cnt_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({HCount, VCount}),
      .q     ({hcount_d, vcount_d})
   );

   sig_delay #(.W(2), .DEPTH(CARD_LAT), .RST_VAL(2'b11)) u_sync_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({hsync_in, vsync_in}),
      .q     ({hsync_d, vsync_d})
   );

   sig_delay #(.W(1), .DEPTH(CARD_LAT), .RST_VAL(1'b0)) u_von_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (video_on_in),
      .q     (video_on_d)
   );

   logic       vsync_d_q;
   logic       vs_fall;
   logic [7:0] frame_cnt;
   logic [3:0] cursor_pos_q;
   logic       cursor_en_q;

   assign vs_fall = vsync_d_q & ~vsync_d;

   // Count frames and latch the cursor only at frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d_q    <= 1'b1;
         frame_cnt    <= 8'd0;
         cursor_pos_q <= 4'd0;
         cursor_en_q  <= 1'b0;
      end else begin
         vsync_d_q <= vsync_d;
         if (vs_fall) begin
            frame_cnt    <= frame_cnt + 8'd1;
            cursor_pos_q <= cursor_pos;
            cursor_en_q  <= cursor_en;
         end
      end
   end

   logic [10:0] px_x;
   logic [10:0] px_y;
   logic [10:0] box_xl;
   logic [10:0] box_yt;
   logic        in_box;
   logic        near_edge;
   logic        on_border;
   logic        cursor_vis;

   // Cursor box geometry in 11 bits so the right/bottom edges never wrap.
   always_comb begin
      px_x   = {1'b0, hcount_d};
      px_y   = {1'b0, vcount_d};
      box_xl = 11'(GRID_X0) + 11'(CELL) * {9'd0, cursor_pos_q[1:0]};
      box_yt = 11'(GRID_Y0) + 11'(CELL) * {9'd0, cursor_pos_q[3:2]};
      in_box = (px_x >= box_xl) && (px_x < box_xl + 11'(CELL)) &&
               (px_y >= box_yt) && (px_y < box_yt + 11'(CELL));
      near_edge = (px_x < box_xl + 11'(BORDER)) ||
                  (px_x >= box_xl + 11'(CELL - BORDER)) ||
                  (px_y < box_yt + 11'(BORDER)) ||
                  (px_y >= box_yt + 11'(CELL - BORDER));
      on_border  = in_box && near_edge;
      cursor_vis = cursor_en_q && !frame_cnt[BLINK_BIT];
   end

   logic  card_hit;
   rgb9_t card_px;

   // Lowest-index active card wins; descending scan lets it overwrite.
   always_comb begin
      card_hit = 1'b0;
      card_px  = '0;
      for (int i = NCARDS - 1; i >= 0; i--) begin
         if (card_on[i]) begin
            card_hit = 1'b1;
            card_px  = matched[i] ? rgb9_dim(card_rgb[9*i +: 9])
                                  : card_rgb[9*i +: 9];
         end
      end
   end

   rgb9_t pix_next;

   // Layer priority: blanking, cursor, card, background.
   always_comb begin
      pix_next = BG_RGB;
      if (!video_on_d)
         pix_next = '0;
      else if (cursor_vis && on_border)
         pix_next = CURSOR_RGB;
      else if (card_hit)
         pix_next = card_px;
   end

   // Output register drives the VGA pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb   <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         rgb   <= pix_next;
         hsync <= hsync_d;
         vsync <= vsync_d;
      end
   end

endmodule
